// File: rtl/id_checker_pkg.sv
// id_checker_pkg: shared constants, state encoding and helpers for the player ID checker.
//   ID_W        - width of a player ID (four BCD digits)
//   ROM_DEPTH   - number of entries in the ID ROM
//   GUEST_ID    - ID that logs in as guest when GUEST_LOGIN_EN is defined
//   GUEST_INDEX - player index reported for a guest login
//   LAST_INDEX  - highest ROM entry searched (entry 7 is reserved for the guest
//                 when GUEST_LOGIN_EN is defined)
// Configuration macro: GUEST_LOGIN_EN
package id_checker_pkg;

    localparam int ID_W      = 16;
    localparam int ROM_DEPTH = 8;
    localparam int IDX_W     = $clog2(ROM_DEPTH);

    localparam logic [ID_W-1:0]  GUEST_ID    = 16'h0000;
    localparam logic [IDX_W-1:0] GUEST_INDEX = 3'd7;

`ifdef GUEST_LOGIN_EN
    localparam logic [IDX_W-1:0] LAST_INDEX = 3'd6;
`else
    localparam logic [IDX_W-1:0] LAST_INDEX = 3'd7;
`endif

    typedef enum logic [3:0] {
        IDLE,
        DIGIT1,
        DIGIT2,
        DIGIT3,
        DIGIT4,
        FETCH,
        CYC1,
        CYC2,
        CATCH,
        COMPARE,
        MATCHED
    } state_t;

    // Replace one BCD digit of an ID; pos 0 is the most significant digit.
    function automatic logic [ID_W-1:0] set_digit(
        input logic [ID_W-1:0] id,
        input logic [1:0]      pos,
        input logic [3:0]      digit
    );
        logic [ID_W-1:0] r;
        r = id;
        r[4*(3-int'(pos)) +: 4] = digit;
        return r;
    endfunction

endpackage

// File: rtl/id_checker.sv
// id_checker: collects a 4-digit player ID and linearly searches the ID ROM for it.
// Ports:
//   clk                 in   system clock, rising edge
//   rst                 in   asynchronous active-low reset
//   b_id                in   one-cycle button pulse accepting idDigit
//   idDigit             in   BCD digit from the switches
//   ROM_data            in   ROM word at ROM_addr (MSD in [15:12])
//   logoutIN            in   one-cycle logout pulse from the password stage
//   ROM_addr            out  ROM address = entry index being searched
//   matchedID           out  one-cycle pulse, ID found
//   internalPlayerIDOUT out  matched entry index, held until logout
//   isGuestOUT          out  high while the current login is the guest login
//   idError             out  one-cycle pulse, ID not found
//   searching           out  high while the search states are active
// Configuration macro: GUEST_LOGIN_EN (guest login with ID 0000 bypasses the ROM).
module id_checker
    import id_checker_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             b_id,
    input  logic [3:0]       idDigit,
    input  logic [ID_W-1:0]  ROM_data,
    input  logic             logoutIN,
    output logic [4:0]       ROM_addr,
    output logic             matchedID,
    output logic [IDX_W-1:0] internalPlayerIDOUT,
    output logic             isGuestOUT,
    output logic             idError,
    output logic             searching
);

`ifdef GUEST_LOGIN_EN
    localparam logic GUEST_EN = 1'b1;
`else
    localparam logic GUEST_EN = 1'b0;
`endif

    state_t           state, state_n;
    logic [ID_W-1:0]  user_id, user_id_n;
    logic [ID_W-1:0]  rom_id, rom_id_n;
    logic [IDX_W-1:0] index, index_n;
    logic [IDX_W-1:0] player_n;
    logic [4:0]       addr_n;
    logic             matched_n, error_n, guest_n;
    // Set in FETCH when the guest ID is recognised so COMPARE reports the
    // guest login one cycle later without touching the ROM.
    logic             guest_hit, guest_hit_n;

    assign searching = state inside {FETCH, CYC1, CYC2, CATCH, COMPARE};

    always_comb begin
        state_n     = state;
        user_id_n   = user_id;
        rom_id_n    = rom_id;
        index_n     = index;
        addr_n      = ROM_addr;
        player_n    = internalPlayerIDOUT;
        guest_n     = isGuestOUT;
        guest_hit_n = guest_hit;
        matched_n   = 1'b0;
        error_n     = 1'b0;
        case (state)
            IDLE: begin
                user_id_n   = '0;
                rom_id_n    = '0;
                index_n     = '0;
                addr_n      = '0;
                player_n    = '0;
                guest_n     = 1'b0;
                guest_hit_n = 1'b0;
                state_n     = DIGIT1;
            end
            DIGIT1: if (b_id) begin
                user_id_n = set_digit(user_id, 2'd0, idDigit);
                state_n   = DIGIT2;
            end
            DIGIT2: if (b_id) begin
                user_id_n = set_digit(user_id, 2'd1, idDigit);
                state_n   = DIGIT3;
            end
            DIGIT3: if (b_id) begin
                user_id_n = set_digit(user_id, 2'd2, idDigit);
                state_n   = DIGIT4;
            end
            DIGIT4: if (b_id) begin
                user_id_n = set_digit(user_id, 2'd3, idDigit);
                index_n   = '0;
                state_n   = FETCH;
            end
            FETCH: begin
                addr_n = {2'b00, index};
                if (GUEST_EN && index == '0 && user_id == GUEST_ID) begin
                    guest_hit_n = 1'b1;
                    state_n     = COMPARE;
                end else begin
                    state_n = CYC1;
                end
            end
            CYC1: state_n = CYC2;
            CYC2: state_n = CATCH;
            CATCH: begin
                rom_id_n = ROM_data;
                state_n  = COMPARE;
            end
            COMPARE: begin
                if (guest_hit) begin
                    matched_n   = 1'b1;
                    player_n    = GUEST_INDEX;
                    guest_n     = 1'b1;
                    guest_hit_n = 1'b0;
                    state_n     = MATCHED;
                end else if (rom_id == user_id) begin
                    matched_n = 1'b1;
                    player_n  = index;
                    guest_n   = 1'b0;
                    state_n   = MATCHED;
                end else if (index == LAST_INDEX) begin
                    error_n   = 1'b1;
                    user_id_n = '0;
                    index_n   = '0;
                    state_n   = DIGIT1;
                end else begin
                    index_n = index + 3'd1;
                    state_n = FETCH;
                end
            end
            MATCHED: if (logoutIN) begin
                player_n = '0;
                guest_n  = 1'b0;
                state_n  = IDLE;
            end
            default: begin
                user_id_n   = '0;
                rom_id_n    = '0;
                index_n     = '0;
                addr_n      = '0;
                player_n    = '0;
                guest_n     = 1'b0;
                guest_hit_n = 1'b0;
                state_n     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            user_id             <= '0;
            rom_id              <= '0;
            index               <= '0;
            guest_hit           <= 1'b0;
            ROM_addr            <= '0;
            matchedID           <= 1'b0;
            idError             <= 1'b0;
            internalPlayerIDOUT <= '0;
            isGuestOUT          <= 1'b0;
        end else begin
            state               <= state_n;
            user_id             <= user_id_n;
            rom_id              <= rom_id_n;
            index               <= index_n;
            guest_hit           <= guest_hit_n;
            ROM_addr            <= addr_n;
            matchedID           <= matched_n;
            idError             <= error_n;
            internalPlayerIDOUT <= player_n;
            isGuestOUT          <= guest_n;
        end
    end

endmodule

// File: tb/tb_id_checker.sv
// tb_id_checker: randomized scoreboard bench for id_checker with a ROM lookup model.
module tb_id_checker;

`ifdef GUEST_LOGIN_EN
    localparam int LAST = 6;
`else
    localparam int LAST = 7;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        b_id = 1'b0;
    logic        logoutIN = 1'b0;
    logic [3:0]  idDigit = 4'd0;
    logic [15:0] ROM_data;
    logic [4:0]  ROM_addr;
    logic        matchedID, isGuestOUT, idError, searching;
    logic [2:0]  internalPlayerIDOUT;
    logic [15:0] rom [0:31];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int resp_cnt = 0;

    typedef struct {
        int kind;
        int player;
        int guest;
        int t;
        int addr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    id_checker dut (
        .clk(clk),
        .rst(rst),
        .b_id(b_id),
        .idDigit(idDigit),
        .ROM_data(ROM_data),
        .logoutIN(logoutIN),
        .ROM_addr(ROM_addr),
        .matchedID(matchedID),
        .internalPlayerIDOUT(internalPlayerIDOUT),
        .isGuestOUT(isGuestOUT),
        .idError(idError),
        .searching(searching)
    );

    assign ROM_data = rom[ROM_addr];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every matchedID/idError pulse must match the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (matchedID || idError) begin
            resp_cnt++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got matched=%0d error=%0d want none at cycle %0d",
                         matchedID, idError, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("resp_kind", int'({idError, matchedID}), mon_e.kind);
                chk("resp_edge", cyc, mon_e.t);
                chk("resp_rom_addr", int'(ROM_addr), mon_e.addr);
                chk("resp_player", int'(internalPlayerIDOUT), mon_e.player);
                chk("resp_guest", int'(isGuestOUT), mon_e.guest);
                chk("resp_searching", int'(searching), 0);
            end
        end
    end

    // Reference: first ROM entry equal to the ID wins; each probe costs 5 cycles.
    function automatic exp_t model(input logic [15:0] id, input int t0);
        exp_t e;
`ifdef GUEST_LOGIN_EN
        if (id == 16'h0000) begin
            e = '{1, 7, 1, t0 + 2, 0};
            return e;
        end
`endif
        for (int k = 0; k <= LAST; k++) begin
            if (rom[k] == id) begin
                e = '{1, k, 0, t0 + 5 * k + 5, k};
                return e;
            end
        end
        e = '{2, 0, 0, t0 + 5 * (LAST + 1), LAST};
        return e;
    endfunction

    function automatic logic [15:0] rand_bcd(input int lo, input int hi);
        return {4'($urandom_range(lo, hi)), 4'($urandom_range(lo, hi)),
                4'($urandom_range(lo, hi)), 4'($urandom_range(lo, hi))};
    endfunction

    // Press four digits with random gaps; stray logout pulses must be ignored.
    task automatic enter(input logic [15:0] id, output int t0);
        t0 = 0;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) begin
                logoutIN = ($urandom_range(0, 2) == 0);
                @(negedge clk);
                logoutIN = 1'b0;
            end
            b_id = 1'b1;
            idDigit = id[15 - 4 * i -: 4];
            if (i == 3) t0 = cyc + 1;
            @(negedge clk);
            b_id = 1'b0;
        end
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
            b_id = searching && ($urandom_range(0, 1) == 1);
            idDigit = 4'($urandom_range(0, 9));
            logoutIN = searching && ($urandom_range(0, 3) == 0);
        end
        b_id = 1'b0;
        logoutIN = 1'b0;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got no response want %0d pending at cycle %0d", q.size(), cyc);
            q.delete();
        end
    endtask

    task automatic run_id(input logic [15:0] id);
        int   t0;
        exp_t e;
        enter(id, t0);
        e = model(id, t0);
        q.push_back(e);
        wait_resp();
        if (e.kind == 1) begin
            repeat (3) begin
                b_id = 1'b1;
                idDigit = 4'($urandom_range(0, 9));
                @(negedge clk);
                b_id = 1'b0;
                chk("hold_player", int'(internalPlayerIDOUT), e.player);
                chk("hold_guest", int'(isGuestOUT), e.guest);
            end
            logoutIN = 1'b1;
            @(negedge clk);
            logoutIN = 1'b0;
            chk("logout_player", int'(internalPlayerIDOUT), 0);
            chk("logout_guest", int'(isGuestOUT), 0);
            @(negedge clk);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rom_addr"}, int'(ROM_addr), 0);
        chk({tag, "_matched"}, int'(matchedID), 0);
        chk({tag, "_player"}, int'(internalPlayerIDOUT), 0);
        chk({tag, "_guest"}, int'(isGuestOUT), 0);
        chk({tag, "_error"}, int'(idError), 0);
        chk({tag, "_searching"}, int'(searching), 0);
    endtask

    initial begin
        int t0;
        int n0;
        for (int i = 0; i < 32; i++) rom[i] = rand_bcd(1, 8);
        if (rom[0] == 16'h1234 || rom[0] == 16'h5555) rom[0] = 16'h8888;
        rom[1] = 16'h5555;
        rom[2] = 16'h1234;
        rom[4] = 16'h5555;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("digit1_searching", int'(searching), 0);

        run_id(16'h1234);
        run_id(16'h9999);
        run_id(16'h0000);
        run_id(16'h5555);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) run_id(rom[$urandom_range(0, 7)]);
            else run_id(rand_bcd(0, 9));
        end

        // Reset while in CYC2 of entry 3 of a search that would otherwise miss.
        enter(16'h9999, t0);
        while (cyc < t0 + 17) @(negedge clk);
        chk("pre_reset_searching", int'(searching), 1);
        chk("pre_reset_rom_addr", int'(ROM_addr), 3);
        #2 rst = 1'b0;
        #1 chk_zero("midsearch_reset");
        q.delete();
        n0 = resp_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("resp_after_reset", resp_cnt - n0, 0);

        run_id(16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
